prbs_xnor_checker: RTL

//  Serial PRBS checker that consumes a 1-bit stream and self-synchronises a local

---
 rtl/prbs_xnor_checker_pkg.sv | 22 ++
 rtl/prbs_xnor_checker_xnor_lfsr_step.sv | 31 +++
 rtl/prbs_xnor_checker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/prbs_xnor_checker_pkg.sv
// Shared encodings and default LFSR taps for the PRBS XNOR checker.
package prbs_xnor_checker_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Taps N and N-1: PRBS7 x^7+x^6+1, PRBS15 x^15+x^14+1
  localparam logic [31:0] TAPS_7  = 32'h0000_0060;
  localparam logic [31:0] TAPS_15 = 32'h0000_6000;

  function automatic logic [31:0] default_taps(input int n);
    case (n)
      7:       return TAPS_7;
      15:      return TAPS_15;
      default: return 32'd3 << (n - 2);
    endcase
  endfunction

endpackage

// File: rtl/prbs_xnor_checker_xnor_lfsr_step.sv
// One combinational step of the XNOR-feedback LFSR plus the 2-input XNOR cell.
// load=1 shifts in the received bit (seeding), otherwise the predicted bit.
module xnor_lfsr_step
  import prbs_xnor_checker_pkg::*;
#(
  parameter int N = 7
) (
  input  logic [N-1:0] lfsr,
  input  logic         load,
  input  logic         bit_in,
  output logic         pred,
  output logic [N-1:0] lfsr_nxt
);

  localparam logic [N-1:0] TAPS = N'(default_taps(N));

  // Exactly two taps are set, so the reduction XNOR is the two-input XNOR
  assign pred     = ~^(lfsr & TAPS);
  assign lfsr_nxt = {lfsr[N-2:0], load ? bit_in : pred};

endmodule

module xnorGate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/prbs_xnor_checker.sv
// Self-synchronising PRBS checker: seed, verify, lock, count errors, drop lock on bursts.
// Outputs registered one cycle after each valid bit; bit_vld=0 freezes all state.
module prbs_xnor_checker
  import prbs_xnor_checker_pkg::*;
#(
  parameter int N        = 7,
  parameter int LOCK_CNT = 16,
  parameter int WINDOW   = 32,
  parameter int LOSS_TH  = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  localparam int FILL_W  = $clog2(N + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(LOSS_TH + 1);

  state_t             st, st_n;
  logic [N-1:0]       lfsr, lfsr_n, lfsr_nxt;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [MATCH_W-1:0] mcnt, mcnt_n;
  logic [WIN_W-1:0]   win, win_n;
  logic [WERR_W-1:0]  werr, werr_n, werr_sum;
  logic [ERR_W-1:0]   cnt_n;
  logic               seeding, pred, match, err_n;

  assign seeding = (st != ST_VERIFY) && (st != ST_LOCKED);

  xnor_lfsr_step #(.N(N)) u_step (
    .lfsr     (lfsr),
    .load     (seeding),
    .bit_in   (bit_in),
    .pred     (pred),
    .lfsr_nxt (lfsr_nxt)
  );

  xnorGate u_match (
    .a (bit_in),
    .b (pred),
    .y (match)
  );

  always_comb begin
    st_n     = st;
    lfsr_n   = bit_vld ? lfsr_nxt : lfsr;
    fill_n   = fill;
    mcnt_n   = mcnt;
    win_n    = win;
    werr_n   = werr;
    werr_sum = werr + WERR_W'(!match);
    err_n    = 1'b0;
    // Clear first so a coincident error still lands as a count of one
    cnt_n    = clr_err ? '0 : err_cnt;
    if (bit_vld) begin
      case (st)
        ST_VERIFY: begin
          if (!match) begin
            st_n   = ST_SEED;
            fill_n = '0;
          end else if (mcnt == MATCH_W'(LOCK_CNT - 1)) begin
            st_n   = ST_LOCKED;
            win_n  = '0;
            werr_n = '0;
          end else begin
            mcnt_n = mcnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!match) begin
            err_n = 1'b1;
            if (cnt_n != {ERR_W{1'b1}}) cnt_n = cnt_n + 1'b1;
          end
          if (werr_sum >= WERR_W'(LOSS_TH)) begin
            st_n   = ST_SEED;
            fill_n = '0;
          end else if (win == WIN_W'(WINDOW - 1)) begin
            win_n  = '0;
            werr_n = '0;
          end else begin
            win_n  = win + 1'b1;
            werr_n = werr_sum;
          end
        end
        default: begin
          if (fill == FILL_W'(N - 1)) begin
            fill_n = '0;
            // All-ones is the XNOR lock-up state; it can never verify
            if (!(&lfsr_nxt)) begin
              st_n   = ST_VERIFY;
              mcnt_n = '0;
            end
          end else begin
            fill_n = fill + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_SEED;
      lfsr      <= '0;
      fill      <= '0;
      mcnt      <= '0;
      win       <= '0;
      werr      <= '0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      st        <= st_n;
      lfsr      <= lfsr_n;
      fill      <= fill_n;
      mcnt      <= mcnt_n;
      win       <= win_n;
      werr      <= werr_n;
      err_pulse <= err_n;
      err_cnt   <= cnt_n;
    end
  end

  assign locked = (st == ST_LOCKED);
  assign state  = st;

endmodule
